// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE convolution sequencer.
package pe_ctrl_pkg;

    // Width of the weight-shift index driven to the PE (K <= 6).
    localparam int unsigned ShiftWidth = 3;

    typedef enum logic [1:0] {
        Mode2x3x3 = 2'b00,
        Mode4x4   = 2'b01,
        Mode5x5   = 2'b10,
        Mode6x6   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StRun   = 2'b10,
        StDrain = 2'b11
    } state_e;

    // Number of weight shifts per window for a given mode.
    function automatic logic [ShiftWidth-1:0] mode_to_k(input logic [1:0] mode);
        logic [ShiftWidth-1:0] k;
        unique case (mode)
            Mode2x3x3: k = ShiftWidth'(3);
            Mode4x4:   k = ShiftWidth'(4);
            Mode5x5:   k = ShiftWidth'(5);
            Mode6x6:   k = ShiftWidth'(6);
            default:   k = ShiftWidth'(3);
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pe_ctrl_lat_pipe.sv
// Fixed-latency valid+tag delay line. Output appears Depth cycles after input.
// o_busy reports any valid bit still in flight.
module pe_ctrl_lat_pipe #(
    parameter int unsigned Depth    = 2,
    parameter int unsigned TagWidth = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [TagWidth-1:0] i_tag,
    output logic                o_valid,
    output logic [TagWidth-1:0] o_tag,
    output logic                o_busy
);

    logic [Depth-1:0]               valid_q;
    logic [Depth-1:0][TagWidth-1:0] tag_q;

    // Shift valid and tag one stage per cycle; synchronous clear on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q[0] <= i_valid;
            tag_q[0]   <= i_tag;
            for (int unsigned i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign o_valid = valid_q[Depth-1];
    assign o_tag   = tag_q[Depth-1];
    assign o_busy  = |valid_q;

endmodule

// File: rtl/pe_ctrl.sv
// Sequencer for the 6x6 PE convolution datapath: latches a layer config, loads
// the weight rows, streams windows while stepping the weight-shift index, and
// flags PE results after a fixed latency.
// Optional: define PE_CTRL_PERF_EN to add the o_stall_cnt performance counter.
module pe_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ROW_NUM     = 6,
    parameter int unsigned WADDR_WIDTH = 8,
    parameter int unsigned WIN_WIDTH   = 16,
    parameter int unsigned WMEM_RD_LAT = 1,
    parameter int unsigned PSUM_LAT    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic                   i_3x3_sel,
    input  logic [3:0]             i_psum_shift,
    input  logic [WADDR_WIDTH-1:0] i_wgt_base,
    input  logic [WIN_WIDTH-1:0]   i_num_win,
    input  logic                   i_img_valid,
    output logic                   o_img_ready,
    output logic                   o_wmem_rd_en,
    output logic [WADDR_WIDTH-1:0] o_wmem_rd_addr,
    output logic [ROW_NUM-1:0]     o_wrf_wr_en,
    output logic [1:0]             o_mode,
    output logic                   o_3x3_sel,
    output logic [3:0]             o_psum_shift,
    output logic [ShiftWidth-1:0]  o_wgt_shift,
    output logic                   o_psum_valid,
    output logic [ShiftWidth-1:0]  o_psum_shift_tag,
    output logic                   o_busy,
    output logic                   o_done
`ifdef PE_CTRL_PERF_EN
    ,
    output logic [31:0]            o_stall_cnt
`endif
);

    localparam int unsigned RowIdxW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int unsigned RowCntW = $clog2(ROW_NUM + 1);

    // Reject degenerate configurations at elaboration.
    if (DATA_WIDTH == 0 || ROW_NUM == 0 || WMEM_RD_LAT == 0 || PSUM_LAT == 0) begin : g_bad_param
        $error("pe_ctrl: DATA_WIDTH, ROW_NUM, WMEM_RD_LAT and PSUM_LAT must be non-zero");
    end

    state_e                 state_q, state_d;
    logic [1:0]             mode_q;
    logic                   sel_q;
    logic [3:0]             psum_shift_q;
    logic [WADDR_WIDTH-1:0] wgt_base_q;
    logic [WIN_WIDTH-1:0]   num_win_q;
    logic [RowCntW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [ShiftWidth-1:0]  shift_q, shift_d;
    logic [WIN_WIDTH-1:0]   win_cnt_q, win_cnt_d;

    logic                   cfg_load;
    logic                   rd_en;
    logic                   done;
    logic                   handshake;
    logic                   last_shift;
    logic                   last_win;
    logic                   last_wr;
    logic [ShiftWidth-1:0]  k_val;
    logic [ShiftWidth-1:0]  wgt_shift;
    logic                   wrf_valid;
    logic [RowIdxW-1:0]     wrf_tag;
    logic                   wrf_busy;
    logic                   psum_busy;

    assign cfg_load   = (state_q == StIdle) && i_start;
    assign k_val      = mode_to_k(mode_q);
    assign handshake  = (state_q == StRun) && i_img_valid;
    assign last_shift = (shift_q == (k_val - ShiftWidth'(1)));
    assign last_win   = (win_cnt_q == (num_win_q - WIN_WIDTH'(1)));
    assign last_wr    = wrf_valid && (wrf_tag == RowIdxW'(ROW_NUM - 1));
    assign wgt_shift  = (state_q == StRun) ? shift_q : '0;

    // Latch the layer configuration on an accepted start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q       <= '0;
            sel_q        <= 1'b0;
            psum_shift_q <= '0;
            wgt_base_q   <= '0;
            num_win_q    <= '0;
        end else if (cfg_load) begin
            mode_q       <= i_mode;
            sel_q        <= i_3x3_sel;
            psum_shift_q <= i_psum_shift;
            wgt_base_q   <= i_wgt_base;
            num_win_q    <= i_num_win;
        end
    end

    // FSM state and sequencing counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            rd_cnt_q  <= '0;
            shift_q   <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            shift_q   <= shift_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Next-state, counter update, read strobe and completion pulse.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        shift_d   = shift_q;
        win_cnt_d = win_cnt_q;
        rd_en     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StLoad;
                    rd_cnt_d = '0;
                end
            end
            StLoad: begin
                if (rd_cnt_q < RowCntW'(ROW_NUM)) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + RowCntW'(1);
                end
                if (last_wr) begin
                    state_d   = (num_win_q == '0) ? StDrain : StRun;
                    shift_d   = '0;
                    win_cnt_d = '0;
                end
            end
            StRun: begin
                if (i_img_valid) begin
                    if (last_shift) begin
                        shift_d   = '0;
                        win_cnt_d = win_cnt_q + WIN_WIDTH'(1);
                        if (last_win) begin
                            state_d = StDrain;
                        end
                    end else begin
                        shift_d = shift_q + ShiftWidth'(1);
                    end
                end
            end
            StDrain: begin
                // Finish only once no result or weight write is still in flight.
                if (!(psum_busy || wrf_busy)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Delays each weight read to its register-file write enable.
    pe_ctrl_lat_pipe #(
        .Depth    (WMEM_RD_LAT),
        .TagWidth (RowIdxW)
    ) u_wrf_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_en),
        .i_tag   (rd_cnt_q[RowIdxW-1:0]),
        .o_valid (wrf_valid),
        .o_tag   (wrf_tag),
        .o_busy  (wrf_busy)
    );

    // Carries each accepted window and its shift index to the result flag.
    pe_ctrl_lat_pipe #(
        .Depth    (PSUM_LAT),
        .TagWidth (ShiftWidth)
    ) u_psum_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (handshake),
        .i_tag   (wgt_shift),
        .o_valid (o_psum_valid),
        .o_tag   (o_psum_shift_tag),
        .o_busy  (psum_busy)
    );

    // One-hot decode of the delayed row index into register-file write enables.
    always_comb begin
        o_wrf_wr_en = '0;
        for (int unsigned r = 0; r < ROW_NUM; r++) begin
            o_wrf_wr_en[r] = wrf_valid && (wrf_tag == RowIdxW'(r));
        end
    end

    assign o_img_ready    = (state_q == StRun);
    assign o_wmem_rd_en   = rd_en;
    assign o_wmem_rd_addr = wgt_base_q + WADDR_WIDTH'(rd_cnt_q);
    assign o_mode         = mode_q;
    assign o_3x3_sel      = sel_q;
    assign o_psum_shift   = psum_shift_q;
    assign o_wgt_shift    = wgt_shift;
    assign o_busy         = (state_q != StIdle) && !done;
    assign o_done         = done;

`ifdef PE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count RUN cycles starved of input; saturates, cleared by a new start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (cfg_load) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StRun) && !i_img_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed self-checking bench for pe_ctrl.
module tb_pe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        sel;
    logic [3:0]  pshift;
    logic [7:0]  base;
    logic [15:0] nwin;
    logic        img_valid;

    logic        o_img_ready;
    logic        o_wmem_rd_en;
    logic [7:0]  o_wmem_rd_addr;
    logic [5:0]  o_wrf_wr_en;
    logic [1:0]  o_mode;
    logic        o_3x3_sel;
    logic [3:0]  o_psum_shift;
    logic [2:0]  o_wgt_shift;
    logic        o_psum_valid;
    logic [2:0]  o_psum_shift_tag;
    logic        o_busy;
    logic        o_done;
`ifdef PE_CTRL_PERF_EN
    logic [31:0] o_stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int psum_cnt = 0;
    int hs_cnt   = 0;
    int d0, p0, h0;
    logic [7:0] exp_addr;
    logic [5:0] exp_we;

    pe_ctrl u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_mode           (mode),
        .i_3x3_sel        (sel),
        .i_psum_shift     (pshift),
        .i_wgt_base       (base),
        .i_num_win        (nwin),
        .i_img_valid      (img_valid),
        .o_img_ready      (o_img_ready),
        .o_wmem_rd_en     (o_wmem_rd_en),
        .o_wmem_rd_addr   (o_wmem_rd_addr),
        .o_wrf_wr_en      (o_wrf_wr_en),
        .o_mode           (o_mode),
        .o_3x3_sel        (o_3x3_sel),
        .o_psum_shift     (o_psum_shift),
        .o_wgt_shift      (o_wgt_shift),
        .o_psum_valid     (o_psum_valid),
        .o_psum_shift_tag (o_psum_shift_tag),
        .o_busy           (o_busy),
        .o_done           (o_done)
`ifdef PE_CTRL_PERF_EN
        ,
        .o_stall_cnt      (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_psum_valid) psum_cnt <= psum_cnt + 1;
        if (o_img_ready && img_valid) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic s, input logic [3:0] ps,
                            input logic [7:0] b, input logic [15:0] n);
        mode   = m;
        sel    = s;
        pshift = ps;
        base   = b;
        nwin   = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_run;
        repeat (7) tick();
        chk("run_entry", o_img_ready, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ready"}, o_img_ready, 0);
        chk({tag, "_rd_en"}, o_wmem_rd_en, 0);
        chk({tag, "_rd_addr"}, o_wmem_rd_addr, 0);
        chk({tag, "_wr_en"}, o_wrf_wr_en, 0);
        chk({tag, "_shift"}, o_wgt_shift, 0);
        chk({tag, "_psum_valid"}, o_psum_valid, 0);
        chk({tag, "_psum_tag"}, o_psum_shift_tag, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_mode"}, o_mode, 0);
        chk({tag, "_sel"}, o_3x3_sel, 0);
        chk({tag, "_pshift"}, o_psum_shift, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; sel = 1'b0; pshift = 4'h0;
        base = 8'h00; nwin = 16'd0; img_valid = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", o_busy, 0);

        // Mode 11, two windows, valid always high.
        img_valid = 1'b1;
        start_op(2'b11, 1'b0, 4'h7, 8'h10, 16'd2);
        for (int k = 0; k < 6; k++) begin
            exp_addr = 8'h10 + 8'(k);
            exp_we   = (k == 0) ? 6'd0 : 6'(1 << (k - 1));
            chk("t1_rd_en", o_wmem_rd_en, 1);
            chk("t1_rd_addr", o_wmem_rd_addr, exp_addr);
            chk("t1_wr_en", o_wrf_wr_en, exp_we);
            chk("t1_load_ready", o_img_ready, 0);
            tick();
        end
        chk("t1_rd_en_off", o_wmem_rd_en, 0);
        chk("t1_last_wr", o_wrf_wr_en, 6'b100000);
        tick();
        chk("t1_mode", o_mode, 2'b11);
        chk("t1_pshift", o_psum_shift, 4'h7);
        chk("t1_busy", o_busy, 1);
        for (int i = 0; i < 12; i++) begin
            chk("t1_ready", o_img_ready, 1);
            chk("t1_shift", o_wgt_shift, i % 6);
            chk("t1_psum_valid", o_psum_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) chk("t1_psum_tag", o_psum_shift_tag, (i - 2) % 6);
            tick();
        end
        chk("t1_drain_ready", o_img_ready, 0);
        chk("t1_drain_shift", o_wgt_shift, 0);
        chk("t1_d0_psum", o_psum_valid, 1);
        chk("t1_d0_tag", o_psum_shift_tag, 4);
        chk("t1_d0_done", o_done, 0);
        tick();
        chk("t1_d1_psum", o_psum_valid, 1);
        chk("t1_d1_tag", o_psum_shift_tag, 5);
        chk("t1_d1_done", o_done, 0);
        tick();
        chk("t1_d2_psum", o_psum_valid, 0);
        chk("t1_d2_done", o_done, 1);
        chk("t1_d2_busy", o_busy, 0);
        tick();
        chk("t1_idle_done", o_done, 0);
        chk("t1_idle_busy", o_busy, 0);
        chk("t1_cfg_hold", o_mode, 2'b11);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_psum_cnt", psum_cnt, 12);

        // Mode 00, high 3x3 half, three windows.
        d0 = done_cnt; p0 = psum_cnt;
        start_op(2'b00, 1'b1, 4'h2, 8'h40, 16'd3);
        chk("t2_sel_load", o_3x3_sel, 1);
        wait_run();
        for (int i = 0; i < 9; i++) begin
            chk("t2_shift", o_wgt_shift, i % 3);
            chk("t2_sel", o_3x3_sel, 1);
            tick();
        end
        chk("t2_drain", o_img_ready, 0);
        tick();
        tick();
        chk("t2_done", o_done, 1);
        chk("t2_sel_hold", o_3x3_sel, 1);
        tick();
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_psum_cnt", psum_cnt - p0, 9);

        // Mode 01, five-cycle stall at shift 2.
        d0 = done_cnt; p0 = psum_cnt;
        start_op(2'b01, 1'b0, 4'h0, 8'h20, 16'd1);
        wait_run();
        chk("t3_shift0", o_wgt_shift, 0);
        tick();
        chk("t3_shift1", o_wgt_shift, 1);
        tick();
        chk("t3_shift2", o_wgt_shift, 2);
        img_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_shift", o_wgt_shift, 2);
            chk("t3_stall_ready", o_img_ready, 1);
        end
        chk("t3_stall_psum", psum_cnt - p0, 2);
        img_valid = 1'b1;
        tick();
        chk("t3_shift3", o_wgt_shift, 3);
        tick();
        chk("t3_drain", o_img_ready, 0);
        tick();
        tick();
        chk("t3_done", o_done, 1);
        tick();
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk("t3_psum_cnt", psum_cnt - p0, 4);
`ifdef PE_CTRL_PERF_EN
        chk("t3_stall_cnt", o_stall_cnt, 5);
`endif

        // Zero windows with wrapping weight address.
        d0 = done_cnt; p0 = psum_cnt; h0 = hs_cnt;
        start_op(2'b10, 1'b0, 4'h0, 8'hFE, 16'd0);
        for (int k = 0; k < 6; k++) begin
            exp_addr = 8'hFE + 8'(k);
            chk("t4_rd_en", o_wmem_rd_en, 1);
            chk("t4_rd_addr", o_wmem_rd_addr, exp_addr);
            tick();
        end
        chk("t4_last_wr", o_wrf_wr_en, 6'b100000);
        tick();
        chk("t4_ready", o_img_ready, 0);
        chk("t4_done", o_done, 1);
        chk("t4_busy", o_busy, 0);
        tick();
        chk("t4_done_off", o_done, 0);
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_hs_cnt", hs_cnt - h0, 0);
        chk("t4_psum_cnt", psum_cnt - p0, 0);

        // Reset during RUN aborts without completion.
        d0 = done_cnt;
        start_op(2'b11, 1'b1, 4'h9, 8'h00, 16'd2);
        wait_run();
        tick();
        tick();
        tick();
        chk("t5_pre_shift", o_wgt_shift, 3);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t5_rst");
        rst_n = 1'b1;
        tick();
        chk("t5_post_psum", o_psum_valid, 0);
        chk("t5_post_busy", o_busy, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        start_op(2'b01, 1'b0, 4'h1, 8'h30, 16'd1);
        wait_run();
        for (int i = 0; i < 4; i++) begin
            chk("t5_shift", o_wgt_shift, i);
            tick();
        end
        chk("t5_drain", o_img_ready, 0);
        tick();
        tick();
        chk("t5_done", o_done, 1);
        tick();
        chk("t5_done_cnt", done_cnt - d0, 1);

        // Start pulse during RUN is ignored.
        d0 = done_cnt;
        start_op(2'b00, 1'b0, 4'h3, 8'h50, 16'd2);
        wait_run();
        for (int i = 0; i < 6; i++) begin
            chk("t6_shift", o_wgt_shift, i % 3);
            chk("t6_mode", o_mode, 2'b00);
            chk("t6_pshift", o_psum_shift, 4'h3);
            if (i == 2) begin
                start = 1'b1; mode = 2'b11; pshift = 4'hF; base = 8'h00; nwin = 16'd9;
            end
            tick();
            start = 1'b0;
        end
        chk("t6_drain", o_img_ready, 0);
        tick();
        tick();
        chk("t6_done", o_done, 1);
        repeat (4) tick();
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_cfg_mode", o_mode, 2'b00);
        chk("t6_cfg_pshift", o_psum_shift, 4'h3);
        chk("t6_idle_busy", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
